// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the CONV arbiter and its response FIFO.
// No logic; pure declarations.
// Used by conv_arbiter and conv_rsp_fifo through import conv_pkg::*.
package conv_pkg;

    // Default operand width of the CONV adder.
    localparam int DW_DEF = 12;

    // Widest requester id the tag carries (N_REQ up to 8).
    localparam int ID_W_MAX = 3;

    // Result width: an unsigned add of two DW-bit operands never needs more than DW+1 bits.
    function automatic int res_width(input int dw);
        return dw + 1;
    endfunction

    // Width of a requester id; at least one bit even for a single requester.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Round-robin scan position: requester index 'off' places after 'base', wrapping at n.
    function automatic int rr_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

    // Tag travelling alongside an operation through the CONV latency.
    typedef struct packed {
        logic                valid;
        logic [ID_W_MAX-1:0] id;
    } tag_t;

endpackage

// File: rtl/conv_rsp_fifo.sv
// Purpose: small synchronous FIFO holding tagged CONV results until the consumer takes them.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: none internally; the caller's credit scheme guarantees no push when full.
//
// Ports: clk/reset (async active-low), push/push_dat write side, pop read side,
//        head_dat = oldest entry, empty and count status.
module conv_rsp_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [W-1:0]                 push_dat,
    input  logic                         pop,
    output logic [W-1:0]                 head_dat,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is read while count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/conv_arbiter.sv
// Purpose: round-robin share of one external CONV adder among N_REQ requesters, results tagged by id.
// Latency: issue edge to rsp_valid is CONV_LAT+1 cycles when the response FIFO is empty.
// Backpressure: credits (free FIFO slots minus in-flight ops) gate grants; rsp_ready=0 stalls after FIFO_DEPTH issues.
//
// Ports: req_valid/req_ready + req_data0/1 (requester i at [i*DW +: DW]) on the request side,
//        CONV_iData0/1 (registered) and CONV_oData to the adder beside this block,
//        rsp_valid/rsp_ready/rsp_id/rsp_data on the response side. reset is async active-low.
module conv_arbiter
    import conv_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int DW       = DW_DEF,
    parameter int CONV_LAT = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*DW-1:0]           req_data0,
    input  logic [N_REQ*DW-1:0]           req_data1,
    output logic [DW-1:0]                 CONV_iData0,
    output logic [DW-1:0]                 CONV_iData1,
    input  logic [DW:0]                   CONV_oData,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [id_width(N_REQ)-1:0]    rsp_id,
    output logic [DW:0]                   rsp_data
);
    localparam int RW         = res_width(DW);
    localparam int IDW        = id_width(N_REQ);
    localparam int FIFO_DEPTH = CONV_LAT + 2;
    localparam int CW         = $clog2(FIFO_DEPTH + 1);
    localparam int FW         = RW + IDW;

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]  credits_q, credits_d;
    logic [DW-1:0]  op0_q, op0_d;
    logic [DW-1:0]  op1_q, op1_d;
    tag_t           tag_q [CONV_LAT+1];
    tag_t           tag_d [CONV_LAT+1];

    logic           gnt_vld;
    logic [IDW-1:0] gnt_id;
    logic           issue;
    logic           pop;
    logic           push;
    logic [FW-1:0]  push_dat;
    logic [FW-1:0]  head_dat;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic [CW-1:0]  inflight;

    // Grant: first valid requester at or after the pointer, only while a FIFO slot is reserved-free.
    // Held off during reset so req_ready reads zero even though credits reset to full.
    always_comb begin
        gnt_vld   = 1'b0;
        gnt_id    = '0;
        req_ready = '0;
        if (reset && credits_q != '0) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!gnt_vld && req_valid[IDW'(rr_idx(int'(ptr_q), i, N_REQ))]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = IDW'(rr_idx(int'(ptr_q), i, N_REQ));
                end
            end
        end
        if (gnt_vld) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    // req_ready is only raised on a valid requester, so a grant is always an issue.
    assign issue = gnt_vld;
    assign pop   = rsp_valid && rsp_ready;
    assign push  = tag_q[CONV_LAT].valid;

    always_comb begin
        ptr_d     = ptr_q;
        op0_d     = op0_q;
        op1_d     = op1_q;
        credits_d = credits_q;
        tag_d[0]  = '0;
        if (issue) begin
            ptr_d           = IDW'(rr_idx(int'(gnt_id), 1, N_REQ));
            op0_d           = req_data0[int'(gnt_id)*DW +: DW];
            op1_d           = req_data1[int'(gnt_id)*DW +: DW];
            tag_d[0].valid  = 1'b1;
            tag_d[0].id     = ID_W_MAX'(gnt_id);
        end
        // Stage k of the tag line lines up with the CONV result k cycles after the operands launched.
        for (int k = 1; k <= CONV_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end
        case ({issue, pop})
            2'b10:   credits_d = credits_q - 1'b1;
            2'b01:   credits_d = credits_q + 1'b1;
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q     <= '0;
            credits_q <= CW'(FIFO_DEPTH);
            op0_q     <= '0;
            op1_q     <= '0;
            for (int k = 0; k <= CONV_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            ptr_q     <= ptr_d;
            credits_q <= credits_d;
            op0_q     <= op0_d;
            op1_q     <= op1_d;
            for (int k = 0; k <= CONV_LAT; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign CONV_iData0 = op0_q;
    assign CONV_iData1 = op1_q;

    assign push_dat = {tag_q[CONV_LAT].id[IDW-1:0], CONV_oData};

    conv_rsp_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // FIFO storage is not reset, so the response fields are forced to zero while nothing is queued.
    assign rsp_valid = !fifo_empty;
    assign rsp_data  = fifo_empty ? '0 : head_dat[RW-1:0];
    assign rsp_id    = fifo_empty ? '0 : head_dat[FW-1:RW];

    always_comb begin
        inflight = '0;
        for (int k = 0; k <= CONV_LAT; k++) begin
            inflight = inflight + CW'(tag_q[k].valid);
        end
    end

    // Every slot is either a free credit, an operation inside CONV, or a queued response.
    a_credit_balance: assert property (@(posedge clk) disable iff (!reset)
        (int'(credits_q) + int'(fifo_count) + int'(inflight)) == FIFO_DEPTH);

    a_tag_id_range: assert property (@(posedge clk) disable iff (!reset)
        tag_q[CONV_LAT].valid |-> (int'(tag_q[CONV_LAT].id) < N_REQ));

endmodule
